dsa_fetch_seq_simd: RTL and testbench

- Fetch sequencer for the SIMD bilinear datapath.
- On each fetch request it takes the base output coordinate of a SIMD group and maps every lane to source-image coordinates.
- It then issues the four neighbour reads per lane (p00, p01, p10, p11) over a single fixed-latency read port and collects the pixels and fractions into lane registers.
- It pulses fetch_done to the control FSM when the group is complete.

---
 rtl/dsa_fetch_seq_simd.sv | 230 +++++++++++++++++++++++
 tb/tb_dsa_fetch_seq_simd.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dsa_fetch_seq_simd.sv
// Fetch sequencer for the SIMD bilinear datapath: maps a group of output pixels to
// source coordinates, issues the four neighbour reads per lane and collects the
// returned pixels. Optional perf counters are enabled with `define DSA_FETCH_PERF_EN.
module dsa_fetch_seq_simd #(
  parameter int SIMD_WIDTH  = 4,
  parameter int ADDR_WIDTH  = 18,
  parameter int MEM_LATENCY = 2,
  parameter int FRAC_BITS   = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            fetch_req,
  input  logic [15:0]                     base_x,
  input  logic [15:0]                     base_y,
  input  logic [15:0]                     img_width_in,
  input  logic [15:0]                     img_height_in,
  input  logic [15:0]                     img_width_out,
  input  logic [15:0]                     scale_x,
  input  logic [15:0]                     scale_y,
  output logic                            mem_rd_en,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  input  logic [7:0]                      mem_rd_data,
  output logic [SIMD_WIDTH*32-1:0]        pix_out,
  output logic [SIMD_WIDTH*FRAC_BITS-1:0] frac_x_out,
  output logic [FRAC_BITS-1:0]            frac_y_out,
  output logic [SIMD_WIDTH-1:0]           lane_valid,
  output logic                            fetch_done,
  output logic                            busy
`ifdef DSA_FETCH_PERF_EN
  ,
  output logic [31:0]                     perf_reads,
  output logic [31:0]                     perf_groups
`endif
);

  localparam int LANE_W = (SIMD_WIDTH > 1) ? $clog2(SIMD_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE = 3'd0, CALC, ISSUE, DRAIN, DONE} state_t;
  state_t state_reg, state_next;

  logic [15:0] base_x_reg, base_y_reg, w_in_reg, h_in_reg, w_out_reg;
  logic [15:0] scale_x_reg, scale_y_reg;

  logic [15:0]                     x0_calc [SIMD_WIDTH];
  logic [15:0]                     x1_calc [SIMD_WIDTH];
  logic [SIMD_WIDTH-1:0]           lv_calc;
  logic [SIMD_WIDTH*FRAC_BITS-1:0] fx_calc;

  logic [15:0]           x0_reg [SIMD_WIDTH];
  logic [15:0]           x1_reg [SIMD_WIDTH];
  logic [ADDR_WIDTH-1:0] row0_reg, row1_reg;
  logic [LANE_W-1:0]     issue_lane_reg;
  logic [1:0]            issue_nb_reg;

  // Return pipeline: one slot per cycle of memory latency, tagged with lane and neighbour.
  logic [MEM_LATENCY-1:0] pipe_valid_reg;
  logic [LANE_W-1:0]      pipe_lane_reg [MEM_LATENCY];
  logic [1:0]             pipe_nb_reg   [MEM_LATENCY];

  genvar gi;
  generate
    for (gi = 0; gi < SIMD_WIDTH; gi++) begin : g_lane
      logic [31:0] lane_x, sx, sx_int;
      assign lane_x  = {16'd0, base_x_reg} + 32'(gi);
      assign sx      = lane_x * {16'd0, scale_x_reg};
      assign sx_int  = sx >> FRAC_BITS;
      assign x0_calc[gi] = (sx_int < {16'd0, w_in_reg}) ? sx_int[15:0] : w_in_reg - 16'd1;
      assign x1_calc[gi] = (({1'b0, x0_calc[gi]} + 17'd1) < {1'b0, w_in_reg}) ?
                           x0_calc[gi] + 16'd1 : w_in_reg - 16'd1;
      assign lv_calc[gi] = lane_x < {16'd0, w_out_reg};
      assign fx_calc[gi*FRAC_BITS +: FRAC_BITS] = lv_calc[gi] ? sx[FRAC_BITS-1:0] : '0;
    end
  endgenerate

  logic [31:0]           sy, sy_int;
  logic [15:0]           y0_calc, y1_calc;
  logic [ADDR_WIDTH-1:0] row0_calc, row1_calc;

  assign sy      = {16'd0, base_y_reg} * {16'd0, scale_y_reg};
  assign sy_int  = sy >> FRAC_BITS;
  assign y0_calc = (sy_int < {16'd0, h_in_reg}) ? sy_int[15:0] : h_in_reg - 16'd1;
  assign y1_calc = (({1'b0, y0_calc} + 17'd1) < {1'b0, h_in_reg}) ? y0_calc + 16'd1 : h_in_reg - 16'd1;
  // Row bases are shared by every lane, so the multiplies happen once per group.
  assign row0_calc = ADDR_WIDTH'({16'd0, y0_calc} * {16'd0, w_in_reg});
  assign row1_calc = ADDR_WIDTH'({16'd0, y1_calc} * {16'd0, w_in_reg});

  logic [LANE_W-1:0] first_lane, next_lane;
  logic              any_valid, next_found, drain_pending;

  assign any_valid = |lv_calc;

  always_comb begin
    first_lane = '0;
    for (int l = SIMD_WIDTH - 1; l >= 0; l--)
      if (lv_calc[l]) first_lane = LANE_W'(l);
  end

  always_comb begin
    next_lane  = '0;
    next_found = 1'b0;
    for (int l = SIMD_WIDTH - 1; l >= 0; l--)
      if (lane_valid[l] && (LANE_W'(l) > issue_lane_reg)) begin
        next_lane  = LANE_W'(l);
        next_found = 1'b1;
      end
  end

  // The last slot drains on the same edge DONE is entered, so only earlier slots count.
  always_comb begin
    drain_pending = 1'b0;
    for (int k = 0; k < MEM_LATENCY - 1; k++)
      drain_pending = drain_pending | pipe_valid_reg[k];
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (fetch_req) state_next = CALC;
      CALC:    state_next = any_valid ? ISSUE : DONE;
      ISSUE:   if (issue_nb_reg == 2'd3 && !next_found) state_next = DRAIN;
      DRAIN:   if (!drain_pending) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  logic [ADDR_WIDTH-1:0] row_sel;
  logic [15:0]           col_sel;

  always_comb begin
    row_sel    = issue_nb_reg[1] ? row1_reg : row0_reg;
    col_sel    = issue_nb_reg[0] ? x1_reg[issue_lane_reg] : x0_reg[issue_lane_reg];
    mem_rd_en  = (state_reg == ISSUE);
    mem_addr   = '0;
    if (state_reg == ISSUE) mem_addr = row_sel + ADDR_WIDTH'(col_sel);
    fetch_done = (state_reg == DONE);
    busy       = (state_reg != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_x_reg     <= '0;
      base_y_reg     <= '0;
      w_in_reg       <= '0;
      h_in_reg       <= '0;
      w_out_reg      <= '0;
      scale_x_reg    <= '0;
      scale_y_reg    <= '0;
      for (int l = 0; l < SIMD_WIDTH; l++) begin
        x0_reg[l] <= '0;
        x1_reg[l] <= '0;
      end
      row0_reg       <= '0;
      row1_reg       <= '0;
      issue_lane_reg <= '0;
      issue_nb_reg   <= '0;
      lane_valid     <= '0;
      frac_x_out     <= '0;
      frac_y_out     <= '0;
      pix_out        <= '0;
    end else begin
      if (state_reg == IDLE && fetch_req) begin
        base_x_reg  <= base_x;
        base_y_reg  <= base_y;
        w_in_reg    <= img_width_in;
        h_in_reg    <= img_height_in;
        w_out_reg   <= img_width_out;
        scale_x_reg <= scale_x;
        scale_y_reg <= scale_y;
      end
      if (state_reg == CALC) begin
        for (int l = 0; l < SIMD_WIDTH; l++) begin
          x0_reg[l] <= x0_calc[l];
          x1_reg[l] <= x1_calc[l];
        end
        row0_reg       <= row0_calc;
        row1_reg       <= row1_calc;
        lane_valid     <= lv_calc;
        frac_x_out     <= fx_calc;
        frac_y_out     <= sy[FRAC_BITS-1:0];
        pix_out        <= '0;
        issue_lane_reg <= first_lane;
        issue_nb_reg   <= 2'd0;
      end
      if (state_reg == ISSUE) begin
        issue_nb_reg <= issue_nb_reg + 2'd1;
        if (issue_nb_reg == 2'd3) issue_lane_reg <= next_lane;
      end
      if (pipe_valid_reg[MEM_LATENCY-1])
        pix_out[{pipe_lane_reg[MEM_LATENCY-1], pipe_nb_reg[MEM_LATENCY-1], 3'b000} +: 8] <= mem_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid_reg <= '0;
      for (int k = 0; k < MEM_LATENCY; k++) begin
        pipe_lane_reg[k] <= '0;
        pipe_nb_reg[k]   <= '0;
      end
    end else begin
      pipe_valid_reg[0] <= (state_reg == ISSUE);
      pipe_lane_reg[0]  <= issue_lane_reg;
      pipe_nb_reg[0]    <= issue_nb_reg;
      for (int k = 1; k < MEM_LATENCY; k++) begin
        pipe_valid_reg[k] <= pipe_valid_reg[k-1];
        pipe_lane_reg[k]  <= pipe_lane_reg[k-1];
        pipe_nb_reg[k]    <= pipe_nb_reg[k-1];
      end
    end
  end

`ifdef DSA_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_reads  <= '0;
      perf_groups <= '0;
    end else begin
      if (mem_rd_en)  perf_reads  <= perf_reads + 32'd1;
      if (fetch_done) perf_groups <= perf_groups + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dsa_fetch_seq_simd.sv
// Scoreboard bench for dsa_fetch_seq_simd: directed groups push expected results,
// a negedge monitor compares them against each fetch_done.
module tb_dsa_fetch_seq_simd;
  localparam int SW = 4;
  localparam int AW = 18;
  localparam int ML = 2;
  localparam int FB = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            fetch_req = 1'b0;
  logic [15:0]     base_x = '0, base_y = '0, img_width_in = '0, img_height_in = '0;
  logic [15:0]     img_width_out = '0, scale_x = '0, scale_y = '0;
  logic            mem_rd_en;
  logic [AW-1:0]   mem_addr;
  logic [7:0]      mem_rd_data;
  logic [SW*32-1:0] pix_out;
  logic [SW*FB-1:0] frac_x_out;
  logic [FB-1:0]   frac_y_out;
  logic [SW-1:0]   lane_valid;
  logic            fetch_done;
  logic            busy;
`ifdef DSA_FETCH_PERF_EN
  logic [31:0]     perf_reads, perf_groups;
`endif

  dsa_fetch_seq_simd #(.SIMD_WIDTH(SW), .ADDR_WIDTH(AW), .MEM_LATENCY(ML), .FRAC_BITS(FB)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req),
    .base_x(base_x), .base_y(base_y),
    .img_width_in(img_width_in), .img_height_in(img_height_in), .img_width_out(img_width_out),
    .scale_x(scale_x), .scale_y(scale_y),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .pix_out(pix_out), .frac_x_out(frac_x_out), .frac_y_out(frac_y_out),
    .lane_valid(lane_valid), .fetch_done(fetch_done), .busy(busy)
`ifdef DSA_FETCH_PERF_EN
    , .perf_reads(perf_reads), .perf_groups(perf_groups)
`endif
  );

  always #5 clk = ~clk;

  // Source memory: mem[a] = a[7:0], returned ML cycles after the strobe.
  logic [7:0] rd_pipe [ML];
  always @(posedge clk) begin
    rd_pipe[0] <= mem_rd_en ? mem_addr[7:0] : 8'hEE;
    for (int k = 1; k < ML; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_rd_data = rd_pipe[ML-1];

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int           id;
    logic [127:0] pix;
    logic [31:0]  fx;
    logic [7:0]   fy;
    logic [3:0]   lv;
    int           done_edge;
    int           nstr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int total = 0, bad = 0, popped = 0, strobes = 0, req_edge = 0;

  task automatic chk(input string name, input int id, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s vec=%0d actual=%0h required=%0h", name, id, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst) strobes = 0;
    else begin
      if (mem_rd_en) strobes = strobes + 1;
      if (fetch_done) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done edge=%0d actual=1 required=0", edge_cnt);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pix_out",    mon_e.id, 128'(pix_out),    mon_e.pix);
          chk("frac_x_out", mon_e.id, 128'(frac_x_out), 128'(mon_e.fx));
          chk("frac_y_out", mon_e.id, 128'(frac_y_out), 128'(mon_e.fy));
          chk("lane_valid", mon_e.id, 128'(lane_valid), 128'(mon_e.lv));
          chk("done_cycle", mon_e.id, 128'(edge_cnt),   128'(mon_e.done_edge));
          chk("strobes",    mon_e.id, 128'(strobes),    128'(mon_e.nstr));
          $display("txn vec=%0d done_edge=%0d strobes=%0d pix=%0h", mon_e.id, edge_cnt, strobes, pix_out);
          popped++;
        end
        strobes = 0;
      end
    end
  end

  task automatic set_in(input logic [15:0] bx, by, wi, hi, wo, sx, sy);
    base_x = bx; base_y = by; img_width_in = wi; img_height_in = hi;
    img_width_out = wo; scale_x = sx; scale_y = sy;
  endtask

  task automatic expect_grp(input int id, input logic [127:0] pix, input logic [31:0] fx,
                            input logic [7:0] fy, input logic [3:0] lv, input int lat, input int nstr);
    exp_t e;
    e.id = id; e.pix = pix; e.fx = fx; e.fy = fy; e.lv = lv;
    e.done_edge = req_edge + lat; e.nstr = nstr;
    exp_q.push_back(e);
  endtask

  task automatic wait_groups(input int target, input int id);
    for (int i = 0; i < 300 && popped < target; i++) @(negedge clk);
    total++;
    if (popped < target) begin
      bad++;
      $display("FAIL timeout vec=%0d popped=%0d required=%0d", id, popped, target);
    end
  endtask

  task automatic run_one(input int id, input logic [15:0] bx, by, wi, hi, wo, sx, sy,
                         input logic [127:0] pix, input logic [31:0] fx, input logic [7:0] fy,
                         input logic [3:0] lv, input int lat, input int nstr);
    int tgt;
    @(negedge clk);
    set_in(bx, by, wi, hi, wo, sx, sy);
    fetch_req = 1'b1;
    req_edge  = edge_cnt;
    expect_grp(id, pix, fx, fy, lv, lat, nstr);
    tgt = popped + 1;
    @(negedge clk);
    fetch_req = 1'b0;
    wait_groups(tgt, id);
    repeat (2) @(negedge clk);
  endtask

  localparam logic [127:0] PIX_ID   = 128'h0C0B0403_0B0A0302_0A090201_09080100;
  localparam logic [127:0] PIX_MASK = 128'h00000000_00000000_0E0D0605_0D0C0504;
  localparam logic [127:0] PIX_CLMP = 128'h3F3F3F3F_3F3E3F3E_3E3D3E3D_3D3C3D3C;
  localparam logic [127:0] PIX_FRAC = 128'h0A090201_0A090201_09080100_09080100;
  localparam logic [127:0] PIX_ROW  = 128'h18170E0D_17160D0C_16150C0B_15140B0A;

  initial begin
    int tgt;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pix",    0, 128'(pix_out),    128'd0);
    chk("rst_frac_x", 0, 128'(frac_x_out), 128'd0);
    chk("rst_frac_y", 0, 128'(frac_y_out), 128'd0);
    chk("rst_lane_v", 0, 128'(lane_valid), 128'd0);
    chk("rst_ctrl",   0, 128'({fetch_done, busy, mem_rd_en}), 128'd0);
    chk("rst_addr",   0, 128'(mem_addr),   128'd0);
    rst = 1'b0;

    run_one(1, 16'd0, 16'd0, 16'd8, 16'd8, 16'd8, 16'h0100, 16'h0100, PIX_ID,   32'h0, 8'h0, 4'hF, 20, 16);
    run_one(2, 16'd4, 16'd0, 16'd8, 16'd8, 16'd6, 16'h0100, 16'h0100, PIX_MASK, 32'h0, 8'h0, 4'h3, 12, 8);
`ifdef DSA_FETCH_PERF_EN
    chk("perf_reads",  2, 128'(perf_reads),  128'd24);
    chk("perf_groups", 2, 128'(perf_groups), 128'd2);
`endif
    run_one(3, 16'd4, 16'd7, 16'd8, 16'd8, 16'd8, 16'h0100, 16'h0100, PIX_CLMP, 32'h0, 8'h0, 4'hF, 20, 16);
    run_one(4, 16'd0, 16'd0, 16'd8, 16'd8, 16'd8, 16'h0080, 16'h0100, PIX_FRAC, 32'h80008000, 8'h0, 4'hF, 20, 16);
    run_one(5, 16'd8, 16'd0, 16'd8, 16'd8, 16'd8, 16'h0100, 16'h0100, 128'd0,   32'h0, 8'h0, 4'h0, 2, 0);
    run_one(6, 16'd0, 16'd1, 16'd10, 16'd6, 16'd10, 16'h0100, 16'h0180, PIX_ROW, 32'h0, 8'h80, 4'hF, 20, 16);

    // fetch_req pulse during ISSUE must be ignored
    @(negedge clk);
    set_in(16'd0, 16'd0, 16'd8, 16'd8, 16'd8, 16'h0100, 16'h0100);
    fetch_req = 1'b1;
    req_edge  = edge_cnt;
    expect_grp(7, PIX_ID, 32'h0, 8'h0, 4'hF, 20, 16);
    tgt = popped + 1;
    @(negedge clk);
    fetch_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_issue", 7, 128'({busy, mem_rd_en}), 128'd3);
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    wait_groups(tgt, 7);
    repeat (30) @(negedge clk);

    // fetch_req held high: second group accepted in the cycle after DONE with new inputs
    @(negedge clk);
    set_in(16'd0, 16'd0, 16'd8, 16'd8, 16'd8, 16'h0100, 16'h0100);
    fetch_req = 1'b1;
    req_edge  = edge_cnt;
    expect_grp(8, PIX_ID, 32'h0, 8'h0, 4'hF, 20, 16);
    expect_grp(9, PIX_ROW, 32'h0, 8'h80, 4'hF, 41, 16);
    tgt = popped + 2;
    @(negedge clk);
    set_in(16'd0, 16'd1, 16'd10, 16'd6, 16'd10, 16'h0100, 16'h0180);
    repeat (20) @(negedge clk);
    @(negedge clk);
    fetch_req = 1'b0;
    wait_groups(tgt, 9);
    repeat (2) @(negedge clk);

    // reset while draining: outputs clear, late returns ignored, no fetch_done
    @(negedge clk);
    set_in(16'd0, 16'd1, 16'd10, 16'd6, 16'd10, 16'h0100, 16'h0180);
    fetch_req = 1'b1;
    req_edge  = edge_cnt;
    @(negedge clk);
    fetch_req = 1'b0;
    repeat (17) @(negedge clk);
    chk("drain_state", 10, 128'({busy, mem_rd_en}), 128'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_pix",    10, 128'(pix_out),    128'd0);
    chk("rstmid_frac_x", 10, 128'(frac_x_out), 128'd0);
    chk("rstmid_frac_y", 10, 128'(frac_y_out), 128'd0);
    chk("rstmid_lane_v", 10, 128'(lane_valid), 128'd0);
    chk("rstmid_ctrl",   10, 128'({fetch_done, busy, mem_rd_en}), 128'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_late_pix",  10, 128'(pix_out), 128'd0);
    chk("rstmid_late_ctrl", 10, 128'({fetch_done, busy}), 128'd0);
    repeat (3) @(negedge clk);
    run_one(11, 16'd0, 16'd0, 16'd8, 16'd8, 16'd8, 16'h0080, 16'h0100, PIX_FRAC, 32'h80008000, 8'h0, 4'hF, 20, 16);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
